shift_register: RTL and testbench

//   Bidirectional serial-in / parallel-out shift register for small control
//   and datapath staging.

---
 rtl/shift_register.sv | 18 +
 tb/tb_shift_register.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// shift_register: bidirectional serial-in / parallel-out shift register
module shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_left,
  input  logic             shift_right,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);
  logic unused_bits;
  assign unused_bits = ^data_in;
  always_ff @(posedge clk)
    if (rst) data_out <= '0;
    else if (shift_left && !shift_right) data_out <= {data_out[WIDTH-2:0], data_in[0]};
    else if (shift_right && !shift_left) data_out <= {data_in[WIDTH-1], data_out[WIDTH-1:1]};
endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register: directed checks of hold, shift, fill-bit and reset behaviour
module tb_shift_register;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shift_left = 1'b0;
  logic       shift_right = 1'b0;
  logic [3:0] data_in = 4'b0000;
  logic [3:0] data_out;
  int checks = 0;
  int fails = 0;

  shift_register #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .shift_left(shift_left),
    .shift_right(shift_right),
    .data_in(data_in),
    .data_out(data_out)
  );

  always #10 clk = ~clk;

  task automatic step(input logic r, input logic sl, input logic sr, input logic [3:0] din);
    rst = r;
    shift_left = sl;
    shift_right = sr;
    data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (data_out !== 4'b0000) begin
      fails++;
      $display("FAIL reset_plain: got %b expected 0000", data_out);
    end
    step(1'b1, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (data_out !== 4'b0000) begin
      fails++;
      $display("FAIL reset_priority: got %b expected 0000", data_out);
    end
  endtask

  task automatic test_shift_right_fill;
    logic [3:0] exp [5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'b1111);
      checks++;
      if (data_out !== exp[i]) begin
        fails++;
        $display("FAIL shift_right_fill[%0d]: got %b expected %b", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_shift_left_drain;
    logic [3:0] exp [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'b0000);
      checks++;
      if (data_out !== exp[i]) begin
        fails++;
        $display("FAIL shift_left_drain[%0d]: got %b expected %b", i, data_out, exp[i]);
      end
    end
  endtask

  task automatic test_fill_select;
    logic [3:0] exp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'b0001);
      checks++;
      if (data_out !== exp[i]) begin
        fails++;
        $display("FAIL fill_left_bit0[%0d]: got %b expected %b", i, data_out, exp[i]);
      end
    end
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'b0111);
      checks++;
      if (data_out !== 4'b0000) begin
        fails++;
        $display("FAIL fill_right_bit3[%0d]: got %b expected 0000", i, data_out);
      end
    end
  endtask

  task automatic test_hold;
    logic [3:0] bits = 4'b1010;
    logic [3:0] exp [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, 1'b0, {3'b000, bits[i]});
      checks++;
      if (data_out !== exp[3-i]) begin
        fails++;
        $display("FAIL hold_load[%0d]: got %b expected %b", 3-i, data_out, exp[3-i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'b1111);
      checks++;
      if (data_out !== 4'b1010) begin
        fails++;
        $display("FAIL hold_idle[%0d]: got %b expected 1010", i, data_out);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'b1111);
      checks++;
      if (data_out !== 4'b1010) begin
        fails++;
        $display("FAIL hold_both[%0d]: got %b expected 1010", i, data_out);
      end
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 4'b1111);
    step(1'b0, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (data_out !== 4'b1100) begin
      fails++;
      $display("FAIL reset_mid_pre: got %b expected 1100", data_out);
    end
    step(1'b1, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (data_out !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_clear: got %b expected 0000", data_out);
    end
    step(1'b0, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (data_out !== 4'b1000) begin
      fails++;
      $display("FAIL reset_mid_resume: got %b expected 1000", data_out);
    end
  endtask

  initial begin
    test_reset;
    test_shift_right_fill;
    test_shift_left_drain;
    test_fill_select;
    test_hold;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
